mult_result_writer: RTL and testbench

MULT_RESULT_WRITER -- requirements
Module: mult_result_writer

---
 rtl/mult_result_writer_pkg.sv | 15 +
 rtl/mult_result_writer.sv | 156 +++++++++++++++
 tb/tb_mult_result_writer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_result_writer_pkg.sv
// Shared definitions for the multiplier result writer: default widths and
// the collection state machine encoding.
package mult_result_writer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_ADDR_WIDTH = 9;
    localparam int DEFAULT_CTRL_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OVF     = 2'd2
    } state_t;

endpackage

// File: rtl/mult_result_writer.sv
// Collects product limbs (least significant first) from the multiplier,
// writes them to the result memory one cycle later, and reports the
// significant limb count and zero flag when the final limb arrives.
// Limbs past the memory depth are dropped and flagged as overflow.
module mult_result_writer
    import mult_result_writer_pkg::*;
#(
    parameter int g_data_width = DEFAULT_DATA_WIDTH,
    parameter int g_addr_width = DEFAULT_ADDR_WIDTH
) (
    input  logic                    pi_clk,
    input  logic                    pi_rst_n,
    input  logic                    pi_ctrl_valid_n,
    input  logic [g_data_width-1:0] pi_data,
    input  logic                    pi_data_wr_en,
    input  logic                    pi_data_last,
    input  logic                    pi_data_zero,
    output logic [g_addr_width-1:0] po_mem_addr,
    output logic [g_data_width-1:0] po_mem_data,
    output logic                    po_mem_wr_en,
    output logic [g_addr_width:0]   po_size,
    output logic                    po_size_valid,
    output logic                    po_zero,
    output logic                    po_overflow,
    output logic                    po_busy
);

    localparam logic [g_addr_width:0] SIZE_ONE = (g_addr_width + 1)'(1);

    state_t                  state_reg,      state_next;
    logic [g_addr_width-1:0] counter_reg,    counter_next;
    logic [g_addr_width-1:0] hi_index_reg,   hi_index_next;
    logic                    nz_seen_reg,    nz_seen_next;
    logic                    overflow_reg,   overflow_next;
    logic [g_addr_width-1:0] mem_addr_reg,   mem_addr_next;
    logic [g_data_width-1:0] mem_data_reg,   mem_data_next;
    logic                    mem_wr_en_reg,  mem_wr_en_next;
    logic [g_addr_width:0]   size_reg,       size_next;
    logic                    size_valid_reg, size_valid_next;
    logic                    zero_reg,       zero_next;

    // Per-beat helpers: the OR reduction marks a nonzero limb, and the
    // "incl" values already account for the beat presented this cycle so the
    // final limb contributes to the reported size.
    logic                    beat_nonzero;
    logic                    beat_accept;
    logic [g_addr_width-1:0] hi_incl;
    logic                    nz_incl;

    assign beat_nonzero = |pi_data;

    // State register and all registered outputs; reset clears everything.
    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            state_reg      <= ST_IDLE;
            counter_reg    <= '0;
            hi_index_reg   <= '0;
            nz_seen_reg    <= 1'b0;
            overflow_reg   <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
            mem_wr_en_reg  <= 1'b0;
            size_reg       <= '0;
            size_valid_reg <= 1'b0;
            zero_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            counter_reg    <= counter_next;
            hi_index_reg   <= hi_index_next;
            nz_seen_reg    <= nz_seen_next;
            overflow_reg   <= overflow_next;
            mem_addr_reg   <= mem_addr_next;
            mem_data_reg   <= mem_data_next;
            mem_wr_en_reg  <= mem_wr_en_next;
            size_reg       <= size_next;
            size_valid_reg <= size_valid_next;
            zero_reg       <= zero_next;
        end
    end

    // Next-state, memory write and finalisation logic.
    always_comb begin
        state_next      = state_reg;
        counter_next    = counter_reg;
        hi_index_next   = hi_index_reg;
        nz_seen_next    = nz_seen_reg;
        overflow_next   = overflow_reg;
        mem_addr_next   = mem_addr_reg;
        mem_data_next   = mem_data_reg;
        mem_wr_en_next  = 1'b0;
        size_next       = size_reg;
        size_valid_next = 1'b0;
        zero_next       = zero_reg;

        // Beats arriving after the memory is full are not stored and do not
        // affect the significant limb count.
        beat_accept = pi_data_wr_en && (state_reg != ST_OVF);
        hi_incl     = hi_index_reg;
        nz_incl     = nz_seen_reg;
        if (beat_accept && beat_nonzero) begin
            hi_incl = counter_reg;
            nz_incl = 1'b1;
        end

        if (!pi_ctrl_valid_n) begin
            // Abort/arm: drop any partial result, including a beat presented
            // in the same cycle. Reported size/zero keep their last values.
            state_next    = ST_IDLE;
            counter_next  = '0;
            hi_index_next = '0;
            nz_seen_next  = 1'b0;
            overflow_next = 1'b0;
        end else if (pi_data_wr_en) begin
            if (beat_accept) begin
                mem_wr_en_next = 1'b1;
                mem_addr_next  = counter_reg;
                mem_data_next  = pi_data;
                counter_next   = counter_reg + 1'b1;
                hi_index_next  = hi_incl;
                nz_seen_next   = nz_incl;
            end else begin
                overflow_next = 1'b1;
            end

            if (pi_data_last) begin
                // Finalise: the pulse lines up with the last memory write
                // because both are registered from this same beat.
                size_valid_next = 1'b1;
                zero_next       = !nz_incl || pi_data_zero;
                size_next       = zero_next ? SIZE_ONE
                                            : ({1'b0, hi_incl} + SIZE_ONE);
                state_next      = ST_IDLE;
                counter_next    = '0;
                hi_index_next   = '0;
                nz_seen_next    = 1'b0;
            end else begin
                unique case (state_reg)
                    ST_IDLE:    state_next = ST_COLLECT;
                    ST_COLLECT: if (&counter_reg) state_next = ST_OVF;
                    ST_OVF:     state_next = ST_OVF;
                    default:    state_next = ST_IDLE;
                endcase
            end
        end
    end

    assign po_mem_addr   = mem_addr_reg;
    assign po_mem_data   = mem_data_reg;
    assign po_mem_wr_en  = mem_wr_en_reg;
    assign po_size       = size_reg;
    assign po_size_valid = size_valid_reg;
    assign po_zero       = zero_reg;
    assign po_overflow   = overflow_reg;
    assign po_busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mult_result_writer.sv
// Randomized scoreboard bench for mult_result_writer. The driver keeps the
// limbs of the result being collected and derives the expected writes and
// size/zero/overflow report directly from them; a monitor on the falling
// edge pops and compares whenever the DUT writes or reports.
module tb_mult_result_writer;

    localparam int DW    = 64;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic          pi_clk = 1'b0;
    logic          pi_rst_n;
    logic          pi_ctrl_valid_n = 1'b1;
    logic [DW-1:0] pi_data = '0;
    logic          pi_data_wr_en = 1'b0;
    logic          pi_data_last = 1'b0;
    logic          pi_data_zero = 1'b0;
    logic [AW-1:0] po_mem_addr;
    logic [DW-1:0] po_mem_data;
    logic          po_mem_wr_en;
    logic [AW:0]   po_size;
    logic          po_size_valid;
    logic          po_zero;
    logic          po_overflow;
    logic          po_busy;

    mult_result_writer #(.g_data_width(DW), .g_addr_width(AW)) dut (
        .pi_clk          (pi_clk),
        .pi_rst_n        (pi_rst_n),
        .pi_ctrl_valid_n (pi_ctrl_valid_n),
        .pi_data         (pi_data),
        .pi_data_wr_en   (pi_data_wr_en),
        .pi_data_last    (pi_data_last),
        .pi_data_zero    (pi_data_zero),
        .po_mem_addr     (po_mem_addr),
        .po_mem_data     (po_mem_data),
        .po_mem_wr_en    (po_mem_wr_en),
        .po_size         (po_size),
        .po_size_valid   (po_size_valid),
        .po_zero         (po_zero),
        .po_overflow     (po_overflow),
        .po_busy         (po_busy)
    );

    always #5 pi_clk = ~pi_clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [AW:0] size;
        logic        zero;
        logic        ovf;
        logic        with_write;
    } res_t;

    wr_t           exp_wr[$];
    res_t          exp_res[$];
    logic [DW-1:0] cur[$];
    logic          model_ovf = 1'b0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every memory write and every size report.
    always @(negedge pi_clk) begin
        wr_t  w;
        res_t r;
        if (po_mem_wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d, expected no write", po_mem_addr);
            end else begin
                w = exp_wr.pop_front();
                chk("wr_addr", 64'(po_mem_addr), 64'(w.addr));
                chk("wr_data", po_mem_data, w.data);
                $display("write addr=%0d data=0x%0h", po_mem_addr, po_mem_data);
            end
        end
        if (po_size_valid === 1'b1) begin
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_size_valid: got size %0d, expected no report", po_size);
            end else begin
                r = exp_res.pop_front();
                chk("size", 64'(po_size), 64'(r.size));
                chk("zero", 64'(po_zero), 64'(r.zero));
                chk("overflow", 64'(po_overflow), 64'(r.ovf));
                chk("pulse_with_last_write", 64'(po_mem_wr_en), 64'(r.with_write));
                $display("result size=%0d zero=%0b overflow=%0b", po_size, po_zero, po_overflow);
            end
        end
    end

    // Reference: size is one past the highest stored nonzero limb.
    task automatic finalize(input logic zf);
        int   hi;
        int   n;
        int   stored;
        res_t r;
        hi = -1;
        n = cur.size();
        stored = (n < DEPTH) ? n : DEPTH;
        for (int i = 0; i < stored; i++)
            if (cur[i] != '0) hi = i;
        if (n > DEPTH) model_ovf = 1'b1;
        r.zero       = (hi < 0) || zf;
        r.size       = r.zero ? (AW+1)'(1) : (AW+1)'(hi + 1);
        r.ovf        = model_ovf;
        r.with_write = (n <= DEPTH);
        exp_res.push_back(r);
        cur.delete();
    endtask

    task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic last,
                         input logic zf, input logic ctrl_n);
        bit fin;
        fin = 0;
        pi_data_wr_en   = wr;
        pi_data         = d;
        pi_data_last    = last;
        pi_data_zero    = zf;
        pi_ctrl_valid_n = ctrl_n;
        if (!ctrl_n) begin
            cur.delete();
            model_ovf = 1'b0;
        end else if (wr) begin
            if (cur.size() < DEPTH)
                exp_wr.push_back('{addr: AW'(cur.size()), data: d});
            cur.push_back(d);
            if (last) begin
                finalize(zf);
                fin = 1;
            end
        end
        @(posedge pi_clk);
        #1;
        chk("busy", 64'(po_busy), 64'(cur.size() != 0));
        if (fin) chk("size_valid_timing", 64'(po_size_valid), 64'd1);
        pi_data_wr_en   = 1'b0;
        pi_data_last    = 1'b0;
        pi_data_zero    = 1'b0;
        pi_ctrl_valid_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send(input logic [DW-1:0] beats[$], input logic zf, input int gap);
        for (int i = 0; i < beats.size(); i++) begin
            cycle(1'b1, beats[i], (i == beats.size() - 1), zf, 1'b1);
            if (gap > 0 && i != beats.size() - 1) idle(gap);
        end
    endtask

    function automatic logic [DW-1:0] rnd_limb();
        if ($urandom_range(0, 1) == 0) return '0;
        return {$urandom, $urandom};
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_wr_en"}, 64'(po_mem_wr_en), 64'd0);
        chk({tag, "_mem_addr"}, 64'(po_mem_addr), 64'd0);
        chk({tag, "_mem_data"}, po_mem_data, 64'd0);
        chk({tag, "_size"}, 64'(po_size), 64'd0);
        chk({tag, "_size_valid"}, 64'(po_size_valid), 64'd0);
        chk({tag, "_zero"}, 64'(po_zero), 64'd0);
        chk({tag, "_overflow"}, 64'(po_overflow), 64'd0);
        chk({tag, "_busy"}, 64'(po_busy), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] q[$];
        int            len;
        int            k;

        // Power-on reset.
        pi_rst_n = 1'b1;
        #2 pi_rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge pi_clk);
        @(negedge pi_clk);
        pi_rst_n = 1'b1;

        // {5,0,7,0,0}: size 3, first beat right after reset release.
        q = '{64'd5, 64'd0, 64'd7, 64'd0, 64'd0};
        send(q, 1'b0, 0);
        idle(2);

        // Single zero limb flagged zero by the multiplier.
        q = '{64'd0};
        send(q, 1'b1, 0);
        idle(2);

        // 513 limbs: 512 stored, overflow reported one cycle after the last.
        q.delete();
        for (int i = 0; i < DEPTH + 1; i++) q.push_back({$urandom, $urandom} | 64'd1);
        send(q, 1'b0, 0);
        idle(2);
        chk("overflow_sticky", 64'(po_overflow), 64'd1);

        // Abort after three beats, then a fresh {1,2}.
        q = '{64'd9, 64'd8, 64'd7};
        for (int i = 0; i < 3; i++) cycle(1'b1, q[i], 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("overflow_cleared", 64'(po_overflow), 64'd0);
        q = '{64'd1, 64'd2};
        send(q, 1'b0, 0);
        idle(2);

        // All-ones then one, with three idle cycles between beats.
        q = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        send(q, 1'b0, 3);
        idle(2);

        // Asynchronous reset after four of eight beats.
        for (int i = 0; i < 4; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
        @(negedge pi_clk);
        #1 pi_rst_n = 1'b0;
        cur.delete();
        model_ovf = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge pi_clk);
        pi_rst_n = 1'b1;

        // Randomized results with gaps, zero flags and aborts.
        for (int r = 0; r < 40; r++) begin
            len = $urandom_range(1, 10);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(rnd_limb());
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, len - 1);
                for (int i = 0; i < k; i++) cycle(1'b1, q[i], 1'b0, 1'b0, 1'b1);
                cycle(1'($urandom_range(0, 1)), rnd_limb(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end else begin
                send(q, ($urandom_range(0, 5) == 0), $urandom_range(0, 2));
            end
            idle($urandom_range(0, 2));
        end

        idle(4);
        chk("writes_drained", 64'(exp_wr.size()), 64'd0);
        chk("results_drained", 64'(exp_res.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
